ffe_mac_sequencer: RTL and testbench
====================================

// Module: ffe_mac_sequencer
// PURPOSE
//  Controller for the serial FFE multiply-accumulate datapath.
//  - Accepts input samples over a valid/ready handshake and keeps a DEPTH-sample history.
//  - Per sample, issues one tap per cycle (rd_addr = k, rd_data = x[n-k]).
//  - Asserts the store/clear strobe so the datapath emits y[n], and flags that cycle with out_valid.
//  - Sits between the sample source and the datapath; the coefficient table stays inside the datapath.
// PARAMETERS
//  IN_OUT_BUS_WIDTH  12              sample / rd_data width, signed
//  DEPTH             4               number of taps, >= 2
//  ADDR_SIZE         $clog2(DEPTH)   tap index width
// PORTS
//  ffe_clk                input   1          clock
//  rst                    input   1          asynchronous reset, active low
//  in_valid               input   1          sample present
//  in_data                input   IOBW       signed sample x[n]
//  in_ready               output  1          sequencer can accept a sample
//  hist_clr               input   1          request: zero the sample history
//  rd_addr                output  ADDR_SIZE  tap index to datapath
//  rd_data                output  IOBW       history sample for current tap, 0 when not issuing
//  str_out_n_rst_add_reg  output  1          datapath store-output / clear-accumulator strobe
//  out_valid              output  1          datapath y is valid this cycle (same cycle as strobe)
//  busy                   output  1          sequence in progress (state != IDLE)
// BEHAVIOUR
//  - Reset:
//    - state IDLE; history all 0.
//    - rd_addr = 0, rd_data = 0, strobe = 0, out_valid = 0, busy = 0, clr_pend = 0.
//  - Output timing:
//    - All outputs are registered except in_ready.
//    - in_ready = (state == IDLE) || strobe cycle.
//  - Accept at edge A (in_valid & in_ready):
//    - hist[0] <= in_data; hist[i] <= hist[i-1].
//    - State moves to MAC with k = 0.
//  - MAC, cycles A+1 .. A+DEPTH:
//    - rd_addr = k, rd_data = hist[k]; k increments.
//    - Without macro: strobe = out_valid = 1 in the cycle where k = DEPTH-1.
//  - Exit from the strobe cycle:
//    - Next state is MAC (k = 0) if a sample is accepted that cycle, otherwise IDLE.
//    - Back-to-back throughput: 1 sample per DEPTH cycles (DEPTH+1 with macro).
//  - rd_data is forced to 0 whenever no tap is issued, so stale products add 0 to the accumulator.
//  - hist_clr:
//    - Sets sticky clr_pend.
//    - Executed on the first IDLE cycle with no accept: history <= 0, clr_pend <= 0.
//    - A sequence in flight is never aborted.
//    - While clr_pend = 1, in_ready is held 0.
//  - in_valid without in_ready: the sample is held by the source; no state change.
//  - k wraps only through the exit rule; rd_addr never exceeds DEPTH-1.
//  - Reset asserted mid-sequence: immediate return to reset values; no strobe and no out_valid for the partial sum.
// CONFIGURATION
//  FFE_SEQ_PIPELINED_DP_EN, for a datapath with a registered multiplier output:
//  - Defined:
//    - Extra DRAIN state after the last tap: rd_data = 0, rd_addr = 0.
//    - Strobe and out_valid fire in DRAIN (cycle A+DEPTH+1).
//    - in_ready = 1 in DRAIN; an accept in DRAIN starts MAC at k = 0 next cycle (overlap is safe).
//  - Undefined:
//    - No DRAIN state; strobe fires on tap DEPTH-1.
// STRUCTURE
//  - Package ffe_pkg:
//    - state encoding localparams: IDLE, MAC, DRAIN.
//    - default IN_OUT_BUS_WIDTH / DEPTH.
//    - coefficient Q-format constant (11 fractional bits).
//  - Sub-module ffe_sample_delay_line:
//    - shift-in on accept, synchronous clear, indexed read port for hist[k].
//  - FSM, tap counter and output registers stay in this module.
// TESTING
//  Directed scenarios; the bench pairs this block with the datapath. Coefficients: 1024, -512, 320, -128.
//  1. Impulse: in_data = 1024, then zeros; out_valid every DEPTH cycles.
//     -> y = 512, -256, 160, -64, 0.
//  2. Handshake timing: single accept at cycle 10.
//     -> rd_addr = 0,1,2,3 in cycles 11-14.
//     -> strobe and out_valid in cycle 14 (15 with macro).
//     -> in_ready = 0 in cycles 11-13.
//  3. Back-to-back: in_valid held high with DC input 2047.
//     -> one accept every 4 (5) cycles.
//     -> y settles to 1023 - 512 + 319 - 128 = 702 (±1 truncation).
//  4. hist_clr raised in cycle 12 of a sequence.
//     -> sequence completes with its result; clear executes in first IDLE cycle.
//     -> next impulse-free sample 0 gives y = 0.
//  5. Reset pulse at cycle 13 mid-sequence.
//     -> all outputs 0 in the following cycle; no out_valid; in_ready = 1 after release.
//  6. Idle gap of 20 cycles between samples.
//     -> rd_data = 0 throughout; next y is unaffected.

Source files
------------

// File: rtl/ffe_pkg.sv
// Shared definitions for the serial FFE MAC sequencer.
// Holds the sequencer state encoding, default bus geometry and the
// coefficient fixed-point format used by the paired datapath.
package ffe_pkg;

    localparam int FFE_IOBW_DEF   = 12;
    localparam int FFE_DEPTH_DEF  = 4;
    // Coefficients are Q-format with this many fractional bits (1024 = 0.5)
    localparam int COEF_FRAC_BITS = 11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        MAC   = ST_MAC,
        DRAIN = ST_DRAIN
    } seq_state_e;

endpackage

// File: rtl/ffe_sample_delay_line.sv
// DEPTH-entry sample history x[n]..x[n-DEPTH+1].
// The read port looks through a same-cycle shift so the sequencer can
// register hist[k] of the history as it will be after this edge.
module ffe_sample_delay_line
    import ffe_pkg::*;
#(
    parameter int W     = FFE_IOBW_DEF,
    parameter int DEPTH = FFE_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                ffe_clk,
    input  logic                rst,
    input  logic                shift,
    input  logic                clr,
    input  logic signed [W-1:0] shift_data,
    input  logic [AW-1:0]       rd_idx,
    output logic signed [W-1:0] rd_val
);

    logic [DEPTH-1:0][W-1:0] hist;

    // Shift in a new sample on accept; synchronous clear otherwise
    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
        end else if (shift) begin
            hist[0] <= shift_data;
            for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
        end else if (clr) begin
            hist <= '0;
        end
    end

    // Read the post-shift view: index 0 is the incoming sample while shifting
    always_comb begin
        rd_val = hist[rd_idx];
        if (shift) begin
            rd_val = (rd_idx == '0) ? shift_data : hist[rd_idx - 1'b1];
        end
    end

endmodule

// File: rtl/ffe_mac_sequencer.sv
// Tap sequencer for the serial FFE multiply-accumulate datapath.
// Accepts one sample per sequence, walks the taps one per cycle and
// fires the store/clear strobe with out_valid on the last product.
// Optional build macro FFE_SEQ_PIPELINED_DP_EN adds a DRAIN cycle after
// the last tap for datapaths with a registered multiplier output.
module ffe_mac_sequencer
    import ffe_pkg::*;
#(
    parameter int IN_OUT_BUS_WIDTH = FFE_IOBW_DEF,
    parameter int DEPTH            = FFE_DEPTH_DEF,
    parameter int ADDR_SIZE        = $clog2(DEPTH)
) (
    input  logic                               ffe_clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic signed [IN_OUT_BUS_WIDTH-1:0] in_data,
    output logic                               in_ready,
    input  logic                               hist_clr,
    output logic [ADDR_SIZE-1:0]               rd_addr,
    output logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data,
    output logic                               str_out_n_rst_add_reg,
    output logic                               out_valid,
    output logic                               busy
);

    localparam logic [ADDR_SIZE-1:0] LAST_TAP = ADDR_SIZE'(DEPTH - 1);

    seq_state_e                         state, state_nxt;
    logic [ADDR_SIZE-1:0]               k_nxt;
    logic                               strobe_nxt;
    logic                               clr_pend;
    logic                               accept;
    logic                               do_clr;
    logic signed [IN_OUT_BUS_WIDTH-1:0] tap_val;

    // A pending clear blocks new samples so it lands on the next idle cycle
    assign in_ready = ((state == IDLE) || str_out_n_rst_add_reg) && !clr_pend;
    assign accept   = in_valid && in_ready;
    assign do_clr   = (state == IDLE) && clr_pend && !accept;

    ffe_sample_delay_line #(
        .W     (IN_OUT_BUS_WIDTH),
        .DEPTH (DEPTH),
        .AW    (ADDR_SIZE)
    ) u_hist (
        .ffe_clk    (ffe_clk),
        .rst        (rst),
        .shift      (accept),
        .clr        (do_clr),
        .shift_data (in_data),
        .rd_idx     (k_nxt),
        .rd_val     (tap_val)
    );

    // Next state and tap index; rd_addr doubles as the tap counter k
    always_comb begin
        state_nxt  = state;
        k_nxt      = '0;
        strobe_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = MAC;
            end
            MAC: begin
                if (rd_addr == LAST_TAP) begin
`ifdef FFE_SEQ_PIPELINED_DP_EN
                    state_nxt = DRAIN;
`else
                    state_nxt = accept ? MAC : IDLE;
`endif
                end else begin
                    k_nxt = rd_addr + 1'b1;
                end
            end
            DRAIN: begin
                state_nxt = accept ? MAC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef FFE_SEQ_PIPELINED_DP_EN
        strobe_nxt = (state_nxt == DRAIN);
`else
        strobe_nxt = (state_nxt == MAC) && (k_nxt == LAST_TAP);
`endif
    end

    // FSM state and registered outputs; rd_data is zero whenever no tap issues
    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            rd_addr               <= '0;
            rd_data               <= '0;
            str_out_n_rst_add_reg <= 1'b0;
            out_valid             <= 1'b0;
            busy                  <= 1'b0;
            clr_pend              <= 1'b0;
        end else begin
            state                 <= state_nxt;
            rd_addr               <= k_nxt;
            rd_data               <= (state_nxt == MAC) ? tap_val : '0;
            str_out_n_rst_add_reg <= strobe_nxt;
            out_valid             <= strobe_nxt;
            busy                  <= (state_nxt != IDLE);
            clr_pend              <= hist_clr || (clr_pend && !do_clr);
        end
    end

endmodule

// File: tb/tb_ffe_mac_sequencer.sv
// Bench for ffe_mac_sequencer paired with a behavioural MAC datapath.
// Expected outputs come from a sample-history model: y = sum(x[n-k]*c[k]) >>> 11.
module tb_ffe_mac_sequencer;
    import ffe_pkg::*;

    localparam int W     = 12;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
`ifdef FFE_SEQ_PIPELINED_DP_EN
    localparam int LAT = DEPTH + 1;
`else
    localparam int LAT = DEPTH;
`endif

    logic                ffe_clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                hist_clr = 1'b0;
    logic signed [W-1:0] in_data = '0;
    logic                in_ready, strobe, out_valid, busy;
    logic signed [W-1:0] rd_data;
    logic [AW-1:0]       rd_addr;

    int coef[DEPTH] = '{1024, -512, 320, -128};
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int hist_m[DEPTH];
    int acc = 0;
    int dp_prod, dp_sum, ref_sum;
    int y_q[$];
    int exp_q[$];
    int acc_cyc_q[$];

    always #5 ffe_clk = ~ffe_clk;

    ffe_mac_sequencer #(
        .IN_OUT_BUS_WIDTH (W),
        .DEPTH            (DEPTH)
    ) dut (
        .ffe_clk               (ffe_clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_ready              (in_ready),
        .hist_clr              (hist_clr),
        .rd_addr               (rd_addr),
        .rd_data               (rd_data),
        .str_out_n_rst_add_reg (strobe),
        .out_valid             (out_valid),
        .busy                  (busy)
    );

    // Datapath (accumulate rd_data*c[rd_addr], dump on strobe) and reference history
    always @(posedge ffe_clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            acc = 0;
        end else begin
            dp_prod = int'(rd_data) * coef[rd_addr];
            dp_sum  = acc + dp_prod;
            if (out_valid) y_q.push_back(dp_sum >>> COEF_FRAC_BITS);
            acc = strobe ? 0 : dp_sum;
            if (in_valid && in_ready) begin
                for (int i = DEPTH - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
                hist_m[0] = int'(in_data);
                ref_sum = 0;
                for (int i = 0; i < DEPTH; i++) ref_sum += hist_m[i] * coef[i];
                exp_q.push_back(ref_sum >>> COEF_FRAC_BITS);
                acc_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int x, output bit ok);
        int n = 0;
        in_valid = 1'b1;
        in_data  = W'(x);
        while (!in_ready && n < 50) begin
            @(negedge ffe_clk);
            n++;
        end
        ok = in_ready;
        @(negedge ffe_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 50 && (busy || !in_ready); t++) @(negedge ffe_clk);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic test_reset();
        logic [AW+W+3:0] got;
        for (int i = 0; i < DEPTH; i++) hist_m[i] = 0;
        rst = 1'b0;
        repeat (3) @(negedge ffe_clk);
        got = {rd_addr, rd_data, strobe, out_valid, busy, in_ready};
        n_cmp++;
        if (got !== {{(AW+W+3){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", got, {{(AW+W+3){1'b0}}, 1'b1});
        end
        rst = 1'b1;
        @(negedge ffe_clk);
        n_cmp++;
        if ({busy, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: busy/in_ready got %b expected 01", {busy, in_ready});
        end
    endtask

    task automatic test_impulse();
        int xs[5] = '{1024, 0, 0, 0, 0};
        int ry[5] = '{512, -256, 160, -64, 0};
        bit ok;
        y_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            send(xs[i], ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL impulse_accept[%0d]: in_ready never rose", i);
            end
            for (int t = 0; t < 20 && y_q.size() <= i; t++) @(negedge ffe_clk);
            n_cmp++;
            if (y_q.size() <= i) begin
                n_fail++;
                $display("FAIL impulse_y[%0d]: no out_valid, expected %0d", i, ry[i]);
            end else if (y_q[i] !== ry[i]) begin
                n_fail++;
                $display("FAIL impulse_y[%0d]: got %0d expected %0d", i, y_q[i], ry[i]);
            end
        end
        wait_idle();
    endtask

    task automatic test_handshake();
        logic [AW+W+3:0] got, want;
        int x = rnd_sample();
        int ea, ed;
        logic es, er, eb;
        int yv, ev;
        wait_idle();
        y_q.delete(); exp_q.delete();
        repeat (3) @(negedge ffe_clk);
        in_valid = 1'b1;
        in_data  = W'(x);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_idle_ready: got %b expected 1", in_ready);
        end
        @(negedge ffe_clk);
        in_valid = 1'b0;
        for (int j = 1; j <= LAT + 1; j++) begin
            ea = (j <= DEPTH) ? j - 1 : 0;
            ed = (j <= DEPTH) ? hist_m[j-1] : 0;
            es = (j == LAT);
            er = (j >= LAT);
            eb = (j <= LAT);
            got  = {rd_addr, rd_data, strobe, out_valid, in_ready, busy};
            want = {AW'(ea), W'(ed), es, es, er, eb};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL hs_cycle_A+%0d: {addr,data,stb,ov,rdy,busy} got %h expected %h", j, got, want);
            end
            @(negedge ffe_clk);
        end
        n_cmp++;
        if (y_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL hs_y_count: got %0d results expected %0d", y_q.size(), exp_q.size());
        end else begin
            yv = y_q.pop_front();
            ev = exp_q.pop_front();
            n_cmp++;
            if (yv !== ev) begin
                n_fail++;
                $display("FAIL hs_y: got %0d expected %0d", yv, ev);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nb = 10;
        int base, seen, yv, ev, idx;
        wait_idle();
        y_q.delete(); exp_q.delete(); acc_cyc_q.delete();
        in_valid = 1'b1;
        in_data  = W'(2047);
        seen = 0;
        for (int t = 0; t < 200 && acc_cyc_q.size() < nb; t++) begin
            @(negedge ffe_clk);
            if (acc_cyc_q.size() != seen) begin
                seen = acc_cyc_q.size();
                in_data = (seen < 6) ? W'(2047) : W'(rnd_sample());
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc_cyc_q.size() != nb) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d expected %0d", acc_cyc_q.size(), nb);
        end
        for (int i = 1; i < acc_cyc_q.size(); i++) begin
            n_cmp++;
            if (acc_cyc_q[i] - acc_cyc_q[i-1] !== LAT) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles expected %0d", i, acc_cyc_q[i] - acc_cyc_q[i-1], LAT);
            end
        end
        for (int t = 0; t < 40 && y_q.size() < exp_q.size(); t++) @(negedge ffe_clk);
        n_cmp++;
        if (y_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_y_count: got %0d expected %0d", y_q.size(), exp_q.size());
        end
        if (y_q.size() >= 4) begin
            n_cmp++;
            if (y_q[3] !== 703) begin
                n_fail++;
                $display("FAIL b2b_dc_settle: got %0d expected 703", y_q[3]);
            end
        end
        idx = 0;
        while (y_q.size() > 0 && exp_q.size() > 0) begin
            yv = y_q.pop_front();
            ev = exp_q.pop_front();
            n_cmp++;
            if (yv !== ev) begin
                n_fail++;
                $display("FAIL b2b_y[%0d]: got %0d expected %0d", idx, yv, ev);
            end
            idx++;
        end
    endtask

    task automatic test_hist_clr();
        int x1 = int'($urandom_range(500, 2000));
        int yv, ev, t;
        bit ok;
        wait_idle();
        y_q.delete(); exp_q.delete();
        send(x1, ok);
        @(negedge ffe_clk);
        hist_clr = 1'b1;
        @(negedge ffe_clk);
        hist_clr = 1'b0;
        for (t = 0; t < 20 && !out_valid; t++) @(negedge ffe_clk);
        n_cmp++;
        if (!out_valid || !ok) begin
            n_fail++;
            $display("FAIL clr_seq_done: out_valid got %b expected 1", out_valid);
        end
        in_valid = 1'b1;
        in_data  = '0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_block_strobe: in_ready got %b expected 0", in_ready);
        end
        @(negedge ffe_clk);
        n_cmp++;
        if ({busy, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_idle_cycle: busy/in_ready got %b expected 00", {busy, in_ready});
        end
        @(negedge ffe_clk);
        for (int i = 0; i < DEPTH; i++) hist_m[i] = 0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_ready_after: in_ready got %b expected 1", in_ready);
        end
        @(negedge ffe_clk);
        in_valid = 1'b0;
        send(rnd_sample(), ok);
        for (t = 0; t < 40 && y_q.size() < 3; t++) @(negedge ffe_clk);
        n_cmp++;
        if (y_q.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL clr_y_count: got %0d expected 3", y_q.size());
        end else begin
            n_cmp++;
            if (y_q[1] !== 0) begin
                n_fail++;
                $display("FAIL clr_zero_y: got %0d expected 0", y_q[1]);
            end
            for (int i = 0; i < 3; i++) begin
                yv = y_q.pop_front();
                ev = exp_q.pop_front();
                n_cmp++;
                if (yv !== ev) begin
                    n_fail++;
                    $display("FAIL clr_y[%0d]: got %0d expected %0d", i, yv, ev);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW+W+3:0] got;
        bit ok;
        wait_idle();
        y_q.delete(); exp_q.delete();
        send(rnd_sample() | 1, ok);
        @(negedge ffe_clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) hist_m[i] = 0;
        #1;
        got = {rd_addr, rd_data, strobe, out_valid, busy, in_ready};
        n_cmp++;
        if (got !== {{(AW+W+3){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_immediate: got %h expected %h", got, {{(AW+W+3){1'b0}}, 1'b1});
        end
        @(negedge ffe_clk);
        got = {rd_addr, rd_data, strobe, out_valid, busy, in_ready};
        n_cmp++;
        if (got !== {{(AW+W+3){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_next_cycle: got %h expected %h", got, {{(AW+W+3){1'b0}}, 1'b1});
        end
        rst = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (LAT + 2) @(negedge ffe_clk);
        n_cmp++;
        if (y_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_out_valid: got %0d results expected 0", y_q.size());
        end
        n_cmp++;
        if ({busy, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_release: busy/in_ready got %b expected 01", {busy, in_ready});
        end
    endtask

    task automatic test_idle_gap();
        int yv, ev;
        bit ok;
        wait_idle();
        y_q.delete(); exp_q.delete();
        send(rnd_sample(), ok);
        wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge ffe_clk);
            n_cmp++;
            if ({rd_data, rd_addr, out_valid} !== '0) begin
                n_fail++;
                $display("FAIL gap_quiet[%0d]: rd_data %0d rd_addr %0d out_valid %b expected all 0", i, rd_data, rd_addr, out_valid);
            end
        end
        send(rnd_sample(), ok);
        for (int t = 0; t < 40 && y_q.size() < 2; t++) @(negedge ffe_clk);
        n_cmp++;
        if (y_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL gap_y_count: got %0d expected 2", y_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                yv = y_q.pop_front();
                ev = exp_q.pop_front();
                n_cmp++;
                if (yv !== ev) begin
                    n_fail++;
                    $display("FAIL gap_y[%0d]: got %0d expected %0d", i, yv, ev);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_handshake();
        test_back_to_back();
        test_hist_clr();
        test_reset_mid();
        test_idle_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
